// File: rtl/alu_rs_param.sv
// Integer ALU reservation station: dual-CDB operand wakeup, single-cycle ALU, result held under valid/ready.
// Define ALU_RS_AGE_SELECT_EN for oldest-ready issue via an age matrix; otherwise lowest-index ready issues.
module alu_rs_param #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [6:0]               disp_op,
  input  logic [2:0]               disp_funct3,
  input  logic                     disp_flag,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic [XLEN-1:0]          disp_src1,
  input  logic [XLEN-1:0]          disp_src2,
  input  logic                     disp_rdy1,
  input  logic                     disp_rdy2,
  input  logic [TAG_W-1:0]         disp_q1,
  input  logic [TAG_W-1:0]         disp_q2,
  input  logic                     cdb0_valid,
  input  logic [TAG_W-1:0]         cdb0_tag,
  input  logic [XLEN-1:0]          cdb0_data,
  input  logic                     cdb1_valid,
  input  logic [TAG_W-1:0]         cdb1_tag,
  input  logic [XLEN-1:0]          cdb1_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic [XLEN-1:0]          out_data,
  output logic [$clog2(DEPTH):0]   free_count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SH_W  = $clog2(XLEN);
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
    logic [2:0]       funct3;
    logic             flag;
    logic             rdy1;
    logic             rdy2;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [XLEN-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0] free_cnt;
  logic [IDX_W-1:0] free_idx, iss_idx;
  logic [DEPTH-1:0] ready_vec;
  logic             issue_fire, disp_fire, disp_keep;

  // Returns {rdy, value}; CDB0 wins when both ports carry the awaited tag.
  function automatic logic [XLEN:0] snoop(input logic rdy, input logic [TAG_W-1:0] q,
                                          input logic [XLEN-1:0] val);
    snoop = {rdy, val};
    if (!rdy) begin
      if (cdb0_valid && cdb0_tag == q)      snoop = {1'b1, cdb0_data};
      else if (cdb1_valid && cdb1_tag == q) snoop = {1'b1, cdb1_data};
    end
  endfunction

  function automatic logic [XLEN-1:0] alu(input ent_t e);
    logic [SH_W-1:0] sh;
    sh  = e.src2[SH_W-1:0];
    alu = '0;
    case (e.funct3)
      3'b000:  alu = e.flag ? e.src1 - e.src2 : e.src1 + e.src2;
      3'b001:  alu = e.src1 << sh;
      3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(e.src1) < $signed(e.src2)};
      3'b011:  alu = {{(XLEN-1){1'b0}}, e.src1 < e.src2};
      3'b100:  alu = e.src1 ^ e.src2;
      3'b101:  if (e.flag) alu = $signed(e.src1) >>> sh; else alu = e.src1 >> sh;
      3'b110:  alu = e.src1 | e.src2;
      default: alu = e.src1 & e.src2;
    endcase
  endfunction

  always_comb begin
    free_cnt  = '0;
    free_idx  = '0;
    ready_vec = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        free_cnt = free_cnt + CNT_W'(1);
        free_idx = IDX_W'(i);
      end
      ready_vec[i] = ent_q[i].busy && ent_q[i].rdy1 && ent_q[i].rdy2;
    end
  end

`ifdef ALU_RS_AGE_SELECT_EN
  // age_q[i][j] set means entry j was dispatched before entry i.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] busy_vec, iss_mask;

  always_comb begin
    iss_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready_vec[i] && (ready_vec & age_q[i]) == '0) iss_idx = IDX_W'(i);
  end

  always_comb begin
    busy_vec = '0;
    iss_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i] = ent_q[i].busy;
      age_d[i]    = age_q[i];
    end
    if (issue_fire) begin
      iss_mask[iss_idx] = 1'b1;
      for (int i = 0; i < DEPTH; i++) age_d[i][iss_idx] = 1'b0;
    end
    if (disp_keep) begin
      for (int i = 0; i < DEPTH; i++) age_d[i][free_idx] = 1'b0;
      age_d[free_idx] = busy_vec & ~iss_mask;
    end
    if (flush)
      for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    else       for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
  end
`else
  always_comb begin
    iss_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready_vec[i]) iss_idx = IDX_W'(i);
  end
`endif

  always_comb begin
    ent_d       = ent_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    issue_fire  = (ready_vec != '0) && (!out_valid_q || out_ready) && !flush;
    disp_fire   = disp_valid && (free_cnt != '0) && !flush;
    disp_keep   = disp_fire && (disp_op == OP_R || disp_op == OP_I);

    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy) begin
        {ent_d[i].rdy1, ent_d[i].src1} = snoop(ent_q[i].rdy1, ent_q[i].q1, ent_q[i].src1);
        {ent_d[i].rdy2, ent_d[i].src2} = snoop(ent_q[i].rdy2, ent_q[i].q2, ent_q[i].src2);
      end
    end

    if (issue_fire) begin
      ent_d[iss_idx].busy = 1'b0;
      out_valid_d = 1'b1;
      out_tag_d   = ent_q[iss_idx].tag;
      out_data_d  = alu(ent_q[iss_idx]);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // The sub select only applies to R-type adds; srai keeps its flag.
    if (disp_keep) begin
      ent_d[free_idx].busy   = 1'b1;
      ent_d[free_idx].tag    = disp_tag;
      ent_d[free_idx].funct3 = disp_funct3;
      ent_d[free_idx].flag   = disp_flag && (disp_op == OP_R || disp_funct3 != 3'b000);
      ent_d[free_idx].q1     = disp_q1;
      ent_d[free_idx].q2     = disp_q2;
      {ent_d[free_idx].rdy1, ent_d[free_idx].src1} = snoop(disp_rdy1, disp_q1, disp_src1);
      {ent_d[free_idx].rdy2, ent_d[free_idx].src2} = snoop(disp_rdy2, disp_q2, disp_src2);
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
    end
  end

  assign disp_ready = (free_cnt != '0);
  assign free_count = free_cnt;
  assign out_valid  = out_valid_q;
  assign out_tag    = out_tag_q;
  assign out_data   = out_data_q;
endmodule

// File: tb/tb_alu_rs_param.sv
// Bench for alu_rs_param: directed vectors, per-cycle reference model compare, and literal expectations.
module tb_alu_rs_param;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int XLEN  = 32;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush, disp_valid, disp_ready, disp_flag, disp_rdy1, disp_rdy2;
  logic [6:0] disp_op;
  logic [2:0] disp_funct3;
  logic [TAG_W-1:0] disp_tag, disp_q1, disp_q2, cdb0_tag, cdb1_tag, out_tag;
  logic [XLEN-1:0] disp_src1, disp_src2, cdb0_data, cdb1_data, out_data;
  logic cdb0_valid, cdb1_valid, out_valid, out_ready;
  logic [$clog2(DEPTH):0] free_count;

  alu_rs_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_funct3(disp_funct3), .disp_flag(disp_flag), .disp_tag(disp_tag),
    .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .disp_q1(disp_q1), .disp_q2(disp_q2),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .free_count(free_count)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries carry a dispatch sequence number; oldest = smallest seq.
  typedef struct {
    bit busy; logic [TAG_W-1:0] tag; logic [2:0] f3; bit flag; bit rtype;
    bit r1; bit r2; logic [TAG_W-1:0] q1; logic [TAG_W-1:0] q2;
    logic [XLEN-1:0] s1; logic [XLEN-1:0] s2; int seq;
  } m_ent_t;
  m_ent_t m [DEPTH];
  bit m_ov;
  logic [TAG_W-1:0] m_otag;
  logic [XLEN-1:0] m_odata;
  int m_seq;

  function automatic logic [XLEN-1:0] ref_alu(input m_ent_t e);
    int sh;
    logic [XLEN-1:0] r;
    sh = int'(e.s2 % XLEN);
    r = '0;
    case (e.f3)
      3'd0: r = (e.flag && e.rtype) ? e.s1 - e.s2 : e.s1 + e.s2;
      3'd1: r = e.s1 << sh;
      3'd2: r = ($signed(e.s1) < $signed(e.s2)) ? 1 : 0;
      3'd3: r = (e.s1 < e.s2) ? 1 : 0;
      3'd4: r = e.s1 ^ e.s2;
      3'd5: if (e.flag) r = $signed(e.s1) >>> sh; else r = e.s1 >> sh;
      3'd6: r = e.s1 | e.s2;
      default: r = e.s1 & e.s2;
    endcase
    return r;
  endfunction

  function automatic bit cdb_hit(input logic [TAG_W-1:0] q, output logic [XLEN-1:0] d);
    d = '0;
    if (cdb0_valid && cdb0_tag == q) begin d = cdb0_data; return 1'b1; end
    if (cdb1_valid && cdb1_tag == q) begin d = cdb1_data; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (!m[i].busy) n++;
    return n;
  endfunction

  task automatic model_step();
    int pick, slot;
    logic [XLEN-1:0] d;
    pick = -1;
    slot = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m[i].busy && m[i].r1 && m[i].r2) begin
`ifdef ALU_RS_AGE_SELECT_EN
        if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].busy) slot = i;
    for (int i = 0; i < DEPTH; i++)
      if (m[i].busy) begin
        if (!m[i].r1 && cdb_hit(m[i].q1, d)) begin m[i].r1 = 1; m[i].s1 = d; end
        if (!m[i].r2 && cdb_hit(m[i].q2, d)) begin m[i].r2 = 1; m[i].s2 = d; end
      end
    if (pick >= 0 && (!m_ov || out_ready)) begin
      m_ov = 1; m_otag = m[pick].tag; m_odata = ref_alu(m[pick]); m[pick].busy = 0;
    end else if (out_ready) m_ov = 0;
    if (disp_valid && slot >= 0 && (disp_op == OP_R || disp_op == OP_I)) begin
      m[slot].busy = 1; m[slot].tag = disp_tag; m[slot].f3 = disp_funct3;
      m[slot].flag = disp_flag; m[slot].rtype = (disp_op == OP_R);
      m[slot].q1 = disp_q1; m[slot].q2 = disp_q2;
      m[slot].r1 = disp_rdy1; m[slot].s1 = disp_src1;
      m[slot].r2 = disp_rdy2; m[slot].s2 = disp_src2;
      if (!m[slot].r1 && cdb_hit(disp_q1, d)) begin m[slot].r1 = 1; m[slot].s1 = d; end
      if (!m[slot].r2 && cdb_hit(disp_q2, d)) begin m[slot].r2 = 1; m[slot].s2 = d; end
      m[slot].seq = m_seq++;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
      m_ov = 0; m_otag = '0; m_odata = '0; m_seq = 0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
      m_ov = 0;
    end else model_step();
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("free_count", 64'(free_count), 64'(m_free()));
      check("disp_ready", 64'(disp_ready), 64'(m_free() != 0));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      check("out_tag", 64'(out_tag), 64'(m_otag));
      check("out_data", 64'(out_data), 64'(m_odata));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic idle();
    disp_valid = 0; cdb0_valid = 0; cdb1_valid = 0; flush = 0;
  endtask

  task automatic disp_set(input logic [6:0] op, input logic [2:0] f3, input logic fl,
                          input logic [TAG_W-1:0] tg, input logic [XLEN-1:0] s1, input logic r1,
                          input logic [TAG_W-1:0] q1, input logic [XLEN-1:0] s2);
    disp_valid = 1; disp_op = op; disp_funct3 = f3; disp_flag = fl; disp_tag = tg;
    disp_src1 = s1; disp_rdy1 = r1; disp_q1 = q1;
    disp_src2 = s2; disp_rdy2 = 1; disp_q2 = '0;
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic fl; logic [XLEN-1:0] a; logic [XLEN-1:0] b; logic [XLEN-1:0] exp;
  } vec_t;
  vec_t vq[$];
  logic [TAG_W-1:0] order[$];
  logic [TAG_W-1:0] exp_order[3];

  initial begin
    idle();
    disp_op = '0; disp_funct3 = '0; disp_flag = 0; disp_tag = '0; disp_src1 = '0; disp_src2 = '0;
    disp_rdy1 = 0; disp_rdy2 = 0; disp_q1 = '0; disp_q2 = '0;
    cdb0_tag = '0; cdb1_tag = '0; cdb0_data = '0; cdb1_data = '0; out_ready = 1;
    #1 reset = 1;
    step(2);
    reset = 0;
    check("reset free_count", 64'(free_count), DEPTH);
    check("reset disp_ready", 64'(disp_ready), 1);
    check("reset out_valid", 64'(out_valid), 0);

    // addi 5+7, tag 3, then stall for three cycles
    out_ready = 0;
    disp_set(OP_I, 3'b000, 0, 6'd3, 32'd5, 1, '0, 32'd7);
    step(); idle();
    check("addi not yet valid", 64'(out_valid), 0);
    step();
    check("addi valid", 64'(out_valid), 1);
    check("addi tag", 64'(out_tag), 3);
    check("addi data", 64'(out_data), 12);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall valid", 64'(out_valid), 1);
      check("stall data", 64'(out_data), 12);
    end
    out_ready = 1;
    step();
    check("addi taken", 64'(out_valid), 0);

    // sub woken by cdb1, then dual-CDB priority
    disp_set(OP_R, 3'b000, 1, 6'd1, '0, 0, 6'd9, 32'd4);
    step(); idle();
    cdb1_valid = 1; cdb1_tag = 6'd9; cdb1_data = 32'd10;
    step(); idle();
    step();
    check("sub cdb1 data", 64'(out_data), 6);
    check("sub cdb1 tag", 64'(out_tag), 1);
    disp_set(OP_R, 3'b000, 1, 6'd2, '0, 0, 6'd9, 32'd4);
    step(); idle();
    cdb0_valid = 1; cdb0_tag = 6'd9; cdb0_data = 32'd1;
    cdb1_valid = 1; cdb1_tag = 6'd9; cdb1_data = 32'd2;
    step(); idle();
    step();
    check("sub cdb0 priority", 64'(out_data), 64'h0000_0000_FFFF_FFFD);

    // sra with dispatch-cycle bypass from cdb0
    disp_set(OP_R, 3'b101, 1, 6'd4, '0, 0, 6'd5, 32'd4);
    cdb0_valid = 1; cdb0_tag = 6'd5; cdb0_data = 32'h8000_0000;
    step(); idle();
    step();
    check("sra bypass", 64'(out_data), 64'h0000_0000_F800_0000);
    step(2);

    // fill every entry, then free one through issue
    for (int k = 0; k < DEPTH; k++) begin
      disp_set(OP_I, 3'b000, 0, 6'(20 + k), '0, 0, 6'd40, 32'(k));
      step();
    end
    idle();
    check("full free_count", 64'(free_count), 0);
    check("full disp_ready", 64'(disp_ready), 0);
    cdb0_valid = 1; cdb0_tag = 6'd40; cdb0_data = 32'd100;
    step(); idle();
    disp_set(OP_I, 3'b000, 0, 6'd30, 32'd1, 1, '0, 32'd1);
    check("issue cycle disp_ready", 64'(disp_ready), 0);
    step();
    check("after issue disp_ready", 64'(disp_ready), 1);
    check("after issue free_count", 64'(free_count), 1);
    step(); idle();
    step(8);

    // ALU vectors and a dropped opcode
    vq.push_back('{OP_R, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1});
    vq.push_back('{OP_R, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0});
    vq.push_back('{OP_R, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00});
    vq.push_back('{OP_R, 3'b110, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678});
    vq.push_back('{OP_R, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00});
    vq.push_back('{OP_I, 3'b001, 1'b0, 32'd1, 32'h23, 32'd8});
    vq.push_back('{OP_R, 3'b101, 1'b0, 32'h8000_0000, 32'd31, 32'd1});
    vq.push_back('{OP_I, 3'b000, 1'b1, 32'd7, 32'd8, 32'd15});
    vq.push_back('{OP_R, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1});
    vq.push_back('{OP_I, 3'b010, 1'b0, 32'd5, 32'hFFFF_FFFD, 32'd0});
    foreach (vq[k]) begin
      disp_set(vq[k].op, vq[k].f3, vq[k].fl, 6'(k), vq[k].a, 1, '0, vq[k].b);
      step(); idle();
      step();
      check($sformatf("alu vec %0d", k), 64'(out_data), 64'(vq[k].exp));
    end
    disp_set(7'b0000011, 3'b000, 0, 6'd63, 32'd1, 1, '0, 32'd1);
    step(); idle();
    check("dropped op free_count", 64'(free_count), DEPTH);
    step();
    check("dropped op no result", 64'(out_valid), 0);

    // occupy entries 0..2, free 0 and 1, refill so the age order is 2,0,1
    disp_set(OP_I, 3'b000, 0, 6'd10, '0, 0, 6'd20, '0); step();
    disp_set(OP_I, 3'b000, 0, 6'd11, '0, 0, 6'd21, '0); step();
    disp_set(OP_I, 3'b000, 0, 6'd12, '0, 0, 6'd30, '0); step(); idle();
    cdb0_valid = 1; cdb0_tag = 6'd20; cdb1_valid = 1; cdb1_tag = 6'd21;
    step(); idle();
    step(3);
    disp_set(OP_I, 3'b000, 0, 6'd13, '0, 0, 6'd30, '0); step();
    disp_set(OP_I, 3'b000, 0, 6'd14, '0, 0, 6'd30, '0); step(); idle();
    cdb0_valid = 1; cdb0_tag = 6'd30; cdb0_data = 32'd0;
    step(); idle();
    for (int k = 0; k < 4; k++) begin
      step();
      if (out_valid) order.push_back(out_tag);
    end
`ifdef ALU_RS_AGE_SELECT_EN
    exp_order[0] = 6'd12; exp_order[1] = 6'd13; exp_order[2] = 6'd14;
`else
    exp_order[0] = 6'd13; exp_order[1] = 6'd14; exp_order[2] = 6'd12;
`endif
    check("issue count", 64'(order.size()), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("issue order %0d", k), (k < order.size()) ? 64'(order[k]) : 64'hDEAD, 64'(exp_order[k]));

    // flush with a stalled result and three busy entries
    out_ready = 0;
    disp_set(OP_I, 3'b000, 0, 6'd40, 32'd1, 1, '0, 32'd1); step();
    disp_set(OP_I, 3'b000, 0, 6'd41, '0, 0, 6'd50, '0); step();
    disp_set(OP_I, 3'b000, 0, 6'd42, '0, 0, 6'd50, '0); step();
    disp_set(OP_I, 3'b000, 0, 6'd43, '0, 0, 6'd50, '0); step(); idle();
    check("pre-flush valid", 64'(out_valid), 1);
    check("pre-flush free_count", 64'(free_count), DEPTH - 3);
    flush = 1;
    step(); idle();
    check("flush valid", 64'(out_valid), 0);
    check("flush free_count", 64'(free_count), DEPTH);
    cdb0_valid = 1; cdb0_tag = 6'd50;
    step(); idle();
    step();
    check("flushed stays empty", 64'(out_valid), 0);

    // asynchronous reset during a stall
    disp_set(OP_I, 3'b000, 0, 6'd44, 32'd3, 1, '0, 32'd4); step();
    disp_set(OP_I, 3'b000, 0, 6'd45, '0, 0, 6'd60, '0); step(); idle();
    check("pre-reset valid", 64'(out_valid), 1);
    #2 reset = 1;
    #1;
    check("async reset valid", 64'(out_valid), 0);
    check("async reset free_count", 64'(free_count), DEPTH);
    check("async reset data", 64'(out_data), 0);
    check("async reset tag", 64'(out_tag), 0);
    @(negedge clock);
    reset = 0;
    out_ready = 1;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
